// File: rtl/cla_pkg.sv
// Shared definitions for the multi-word carry-lookahead adder.
//   CHUNK_W : width of one lookahead slice (fixed, not overridable)
//   state_e : top-level FSM encoding
//   clog2   : ceiling log2, used to size the chunk index counter
package cla_pkg;

    localparam int unsigned CHUNK_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla16_slice.sv
// Combinational 16-bit carry-lookahead adder slice.
// Four 4-bit lookahead groups feed a second-level carry unit.
// Ports:
//   A, B  : 16-bit operands
//   Cin   : carry into bit 0
//   S     : 16-bit sum
//   Cout  : carry out of bit 15
//   PG/GG : slice-level propagate/generate, for chaining lookahead across slices
module cla16_slice
    import cla_pkg::*;
(
    input  logic [CHUNK_W-1:0] A,
    input  logic [CHUNK_W-1:0] B,
    input  logic               Cin,
    output logic [CHUNK_W-1:0] S,
    output logic               Cout,
    output logic               PG,
    output logic               GG
);

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [4:0]  grp_c;
    logic [15:0] c;

    always_comb begin
        p = A ^ B;
        g = A & B;

        for (int k = 0; k < 4; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        // Second-level unit: carry into each group straight from Cin.
        grp_c[0] = Cin;
        grp_c[1] = grp_g[0] | (grp_p[0] & Cin);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & Cin);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & Cin);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & Cin);

        // In-group carries from the group carry-in.
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end

        S    = p ^ c;
        Cout = grp_c[4];
        PG   = &grp_p;
        GG   = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    end

endmodule

// File: rtl/cla_multiword_adder.sv
// Multi-cycle wide adder: one 16-bit CLA slice per cycle, LSB chunk first,
// carry chained through a register; valid/ready handshake on both sides.
// Optional feature macro: SUBTRACT_EN (adds Sub input; Sub=1 computes A-B).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake (in_ready high only in IDLE)
//   A, B, Cin [, Sub]     : operands, captured on accept
//   out_valid/out_ready   : result handshake
//   S, Cout, OVF          : registered wide sum, carry out, signed overflow
module cla_multiword_adder
    import cla_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHUNK_W*WORDS-1:0] A,
    input  logic [CHUNK_W*WORDS-1:0] B,
    input  logic                     Cin,
`ifdef SUBTRACT_EN
    input  logic                     Sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHUNK_W*WORDS-1:0] S,
    output logic                     Cout,
    output logic                     OVF
);

    localparam int unsigned W     = CHUNK_W * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
`ifdef SUBTRACT_EN
    logic               sub_q, sub_d;
`endif

    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] slice_s;
    logic               slice_cout;
    logic               slice_pg;
    logic               slice_gg;
    logic               unused_pg_gg;

    always_comb begin
        a_chunk = a_q[CHUNK_W*int'(idx_q) +: CHUNK_W];
        b_chunk = b_q[CHUNK_W*int'(idx_q) +: CHUNK_W];
`ifdef SUBTRACT_EN
        if (sub_q) begin
            b_chunk = ~b_chunk;
        end
`endif
    end

    cla16_slice u_slice (
        .A    (a_chunk),
        .B    (b_chunk),
        .Cin  (carry_q),
        .S    (slice_s),
        .Cout (slice_cout),
        .PG   (slice_pg),
        .GG   (slice_gg)
    );

    // Lookahead outputs are reserved for a cross-chunk variant.
    assign unused_pg_gg = slice_pg ^ slice_gg;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef SUBTRACT_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
`ifdef SUBTRACT_EN
                    sub_d = Sub;
                    // Two's-complement subtract: ~B plus forced carry-in of 1.
                    if (Sub) begin
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[CHUNK_W*int'(idx_q) +: CHUNK_W] = slice_s;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    // Same operand signs but different result sign -> overflow.
                    ovf_d   = (a_chunk[CHUNK_W-1] == b_chunk[CHUNK_W-1])
                            && (slice_s[CHUNK_W-1] != a_chunk[CHUNK_W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef SUBTRACT_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign S         = s_q;
    assign Cout      = cout_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_cla_multiword_adder.sv
module tb_cla_multiword_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WORDS=4 instance
    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [63:0] a4 = '0;
    logic [63:0] b4 = '0;
    logic        cin4 = 1'b0;
    logic        sub4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic [63:0] s4;
    logic        cout4;
    logic        ovf4;

    // WORDS=1 instance
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        cin1 = 1'b0;
    logic        sub1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [15:0] s1;
    logic        cout1;
    logic        ovf1;

    cla_multiword_adder #(.WORDS(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .A         (a4),
        .B         (b4),
        .Cin       (cin4),
`ifdef SUBTRACT_EN
        .Sub       (sub4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .S         (s4),
        .Cout      (cout4),
        .OVF       (ovf4)
    );

    cla_multiword_adder #(.WORDS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .A         (a1),
        .B         (b1),
        .Cin       (cin1),
`ifdef SUBTRACT_EN
        .Sub       (sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .S         (s1),
        .Cout      (cout1),
        .OVF       (ovf1)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start4(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic sub);
        @(negedge clk);
        a4 = a;
        b4 = b;
        cin4 = cin;
        sub4 = sub;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
    endtask

    task automatic wait4(output int lat);
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume4();
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        hold_ok;
        logic [63:0] s_snap;

        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0});
        vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                         64'h8000_0000_0000_0000, 1'b0, 1'b1});
        vecs.push_back('{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                         64'h0000_0001_0000_0000, 1'b0, 1'b0});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                         64'd0, 1'b1, 1'b1});
        vecs.push_back('{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                         64'h2345_6789_ABCD_F001, 1'b0, 1'b0});
`ifdef SUBTRACT_EN
        vecs.push_back('{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        vecs.push_back('{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0});
`endif

        // Reset state
        #12;
        check("rst in_ready4", 64'(in_ready4), 64'd1);
        check("rst out_valid4", 64'(out_valid4), 64'd0);
        check("rst S4", s4, 64'd0);
        check("rst Cout/OVF4", {62'd0, cout4, ovf4}, 64'd0);
        check("rst in_ready1", 64'(in_ready1), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors on WORDS=4
        foreach (vecs[i]) begin
            start4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            wait4(lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d S", i), s4, vecs[i].s);
            check($sformatf("vec%0d Cout", i), 64'(cout4), 64'(vecs[i].cout));
            check($sformatf("vec%0d OVF", i), 64'(ovf4), 64'(vecs[i].ovf));
            consume4();
            check($sformatf("vec%0d in_ready after", i), 64'(in_ready4), 64'd1);
        end

        // WORDS=1: single-cycle RUN
        @(negedge clk);
        a1 = 16'hFCFF;
        b1 = 16'hFFC0;
        cin1 = 1'b1;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w1 latency", 64'(lat), 64'd1);
        check("w1 S", 64'(s1), 64'h0000_0000_0000_FCC0);
        check("w1 Cout", 64'(cout1), 64'd1);
        check("w1 OVF", 64'(ovf1), 64'd0);
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        check("w1 in_ready after", 64'(in_ready1), 64'd1);

        // Back-pressure: hold 10 cycles, stray in_valid must be ignored
        start4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        wait4(lat);
        check("bp latency", 64'(lat), 64'd4);
        hold_ok = 1'b1;
        @(negedge clk);
        a4 = 64'h5555_5555_5555_5555;
        b4 = 64'h1111_1111_1111_1111;
        in_valid4 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (!out_valid4 || in_ready4 || s4 !== 64'd0 || cout4 !== 1'b1) begin
                hold_ok = 1'b0;
            end
        end
        check("bp hold stable", 64'(hold_ok), 64'd1);
        @(negedge clk);
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        check("bp in_ready after hs", 64'(in_ready4), 64'd1);
        check("bp out_valid after hs", 64'(out_valid4), 64'd0);

        // Asynchronous reset mid-RUN at idx=2
        start4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        s_snap = s4;
        check("midrun partial S", s_snap, 64'h0000_0000_3333_3333);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid4), 64'd0);
        check("midrst S", s4, 64'd0);
        check("midrst Cout", 64'(cout4), 64'd0);
        check("midrst in_ready", 64'(in_ready4), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start4(64'd3, 64'd4, 1'b0, 1'b0);
        wait4(lat);
        check("post-rst latency", 64'(lat), 64'd4);
        check("post-rst S", s4, 64'd7);
        check("post-rst Cout", 64'(cout4), 64'd0);
        consume4();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
